// File: rtl/mmio_store_queue_pkg.sv
// Shared definitions for the MMIO store queue: register offsets inside the
// 16-byte window, FSM encodings, STATUS bit positions and a STATUS packer.
package mmio_store_queue_pkg;

    // Register offsets, decoded on dataadr[3:0]
    localparam logic [3:0] MMIO_OFF_DATA   = 4'h0;
    localparam logic [3:0] MMIO_OFF_HALT   = 4'h4;
    localparam logic [3:0] MMIO_OFF_STATUS = 4'h8;
    localparam logic [3:0] MMIO_OFF_CLR    = 4'hC;

    // Halt sequencer states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } mmio_state_e;

    // STATUS word layout; [15:0] holds the zero-extended entry count
    localparam int STAT_EMPTY_BIT    = 16;
    localparam int STAT_FULL_BIT     = 17;
    localparam int STAT_OVF_BIT      = 18;
    localparam int STAT_HALT_REQ_BIT = 19;

    function automatic logic [31:0] pack_status(input logic [15:0] count,
                                                input logic        empty,
                                                input logic        full,
                                                input logic        ovf,
                                                input logic        halt_req);
        logic [31:0] s;
        s                    = '0;
        s[15:0]              = count;
        s[STAT_EMPTY_BIT]    = empty;
        s[STAT_FULL_BIT]     = full;
        s[STAT_OVF_BIT]      = ovf;
        s[STAT_HALT_REQ_BIT] = halt_req;
        return s;
    endfunction

endpackage

// File: rtl/mmio_store_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and a combinational
// head. Push is refused only when full and not popping in the same cycle,
// so a full FIFO can accept a push alongside a pop. Async active-low reset
// clears pointers, count and storage so the head reads 0 after reset.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot this edge, so a full FIFO may still take a push
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointer and count next-state; pointers wrap modulo DEPTH
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Control state and storage; contents are discarded on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/mmio_store_queue.sv
// mmio_store_queue: MMIO output peripheral beside dmem on the core data port.
// DATA stores are queued in a FIFO and drained over out_valid/out_ready; a
// HALT store drains the queue then latches halted. The core never stalls, so
// a store to a full queue is dropped and flagged in STATUS.overflow.
// Optional feature macro: MMIO_TIMESTAMP_EN -- when defined, each entry also
// carries the free-running cycle count at push time, shown on out_stamp.
module mmio_store_queue
    import mmio_store_queue_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        is_mmio,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_stamp,
    input  logic        out_ready,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;
`ifdef MMIO_TIMESTAMP_EN
    localparam int FW = 64;
`else
    localparam int FW = 32;
`endif

    mmio_state_e state_q, state_d;
    logic        halt_req_q, halt_req_d;
    logic        overflow_q, overflow_d;

    logic [3:0]    offset;
    logic          wr_data, wr_halt, wr_clr;
    logic          push_req, pop, drop;
    logic [FW-1:0] fifo_wdata, fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    // Address decode: the window is 16 bytes, matched on dataadr[31:4]
    assign offset  = dataadr[3:0];
    assign is_mmio = (dataadr[31:4] == MMIO_BASE[31:4]);
    assign wr_data = memwrite & is_mmio & (offset == MMIO_OFF_DATA);
    assign wr_halt = memwrite & is_mmio & (offset == MMIO_OFF_HALT);
    assign wr_clr  = memwrite & is_mmio & (offset == MMIO_OFF_CLR);

    // Once halted, DATA stores are silently ignored rather than counted as drops
    assign push_req = wr_data & (state_q != ST_HALTED);
    assign pop      = out_valid & out_ready;
    assign drop     = push_req & fifo_full & ~pop;

    assign rd = (is_mmio && offset == MMIO_OFF_STATUS)
              ? pack_status(16'(fifo_count), fifo_empty, fifo_full, overflow_q, halt_req_q)
              : 32'h0;

`ifdef MMIO_TIMESTAMP_EN
    logic [31:0] tstamp_q;

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 32'd1;
        end
    end

    assign fifo_wdata = {tstamp_q, writedata};
    assign out_data   = fifo_rdata[31:0];
    assign out_stamp  = fifo_rdata[63:32];
`else
    assign fifo_wdata = writedata;
    assign out_data   = fifo_rdata;
    assign out_stamp  = 32'h0;
`endif

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push_req),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Flag next-state: CLR is applied first so a same-cycle drop still sets overflow
    always_comb begin
        halt_req_d = halt_req_q | wr_halt;
        overflow_d = overflow_q;
        if (wr_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Halt sequencer state and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            halt_req_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_req_q <= halt_req_d;
            overflow_q <= overflow_d;
        end
    end

    // Halt sequencer next-state: DRAIN waits for an empty queue with no new push
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (wr_halt) state_d = ST_DRAIN;
            ST_DRAIN:  if (fifo_empty && !push_req) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Sequencer and queue outputs
    always_comb begin
        halted    = (state_q == ST_HALTED);
        out_valid = ~fifo_empty;
    end

endmodule
